// File: rtl/arp_req_arb_pkg.sv
// arp_req_arb_pkg: shared state encoding and ARP field widths
package arp_req_arb_pkg;
  localparam int IP_W = 32;
  localparam int MAC_W = 48;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/arp_rr_select.sv
// arp_rr_select: round-robin priority encoder starting the search at ptr
module arp_rr_select #(
  parameter int N = 2,
  parameter int LSB_HIGH_PRIORITY = 1,
  parameter int CL = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CL-1:0] ptr,
  output logic          valid,
  output logic [CL-1:0] index,
  output logic [N-1:0]  grant
);
  logic [CL-1:0] j;
  // Walk from the farthest candidate to the nearest so the nearest hit wins
  always_comb begin
    valid = 1'b0;
    index = '0;
    grant = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = LSB_HIGH_PRIORITY != 0 ? CL'((int'(ptr) + i) % N) : CL'((int'(ptr) + N - i) % N);
      if (req[j]) begin
        valid = 1'b1;
        index = j;
      end
    end
    grant[index] = valid;
  end
endmodule

// File: rtl/arp_req_arb.sv
// arp_req_arb: round-robin sharing of one ARP request/response port among S_COUNT requesters
module arp_req_arb
  import arp_req_arb_pkg::*;
#(
  parameter int S_COUNT = 2,
  parameter int CL_S_COUNT = $clog2(S_COUNT),
  parameter int TIMEOUT = 0,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_COUNT-1:0]      s_arp_request_valid,
  output logic [S_COUNT-1:0]      s_arp_request_ready,
  input  logic [S_COUNT*IP_W-1:0] s_arp_request_ip,
  output logic [S_COUNT-1:0]      m_arp_response_valid,
  input  logic [S_COUNT-1:0]      m_arp_response_ready,
  output logic                    m_arp_response_error,
  output logic [MAC_W-1:0]        m_arp_response_mac,
  output logic                    m_arp_request_valid,
  input  logic                    m_arp_request_ready,
  output logic [IP_W-1:0]         m_arp_request_ip,
  input  logic                    s_arp_response_valid,
  output logic                    s_arp_response_ready,
  input  logic                    s_arp_response_error,
  input  logic [MAC_W-1:0]        s_arp_response_mac,
  output logic                    busy,
  output logic [CL_S_COUNT-1:0]   grant_index
);
  localparam int WDW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  arb_state_t state;
  logic [CL_S_COUNT-1:0] ptr, offer_idx, sel_index;
  logic [S_COUNT-1:0] sel_grant, owner_hot;
  logic [WDW-1:0] wdog;
  logic sel_valid, timeout_hit;
  assign timeout_hit = TIMEOUT != 0 && wdog == WDW'(TIMEOUT - 1);
  assign owner_hot = S_COUNT'(1) << grant_index;
  arp_rr_select #(.N(S_COUNT), .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY), .CL(CL_S_COUNT)) u_sel (
    .req(s_arp_request_valid),
    .ptr(ptr),
    .valid(sel_valid),
    .index(sel_index),
    .grant(sel_grant)
  );
  // IDLE offers ready for one cycle; the following edge is the handshake or a skip
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_arp_request_ready <= '0;
      m_arp_response_valid <= '0;
      m_arp_response_error <= 1'b0;
      m_arp_response_mac <= '0;
      m_arp_request_valid <= 1'b0;
      m_arp_request_ip <= '0;
      s_arp_response_ready <= 1'b0;
      busy <= 1'b0;
      grant_index <= '0;
      ptr <= '0;
      offer_idx <= '0;
      wdog <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|s_arp_request_ready) begin
            s_arp_request_ready <= '0;
            if (s_arp_request_valid[offer_idx]) begin
              m_arp_request_ip <= s_arp_request_ip[offer_idx*IP_W +: IP_W];
              m_arp_request_valid <= 1'b1;
              grant_index <= offer_idx;
              ptr <= offer_idx == CL_S_COUNT'(S_COUNT - 1) ? '0 : offer_idx + 1'b1;
              s_arp_response_ready <= 1'b0;
              busy <= 1'b1;
              state <= REQ;
            end
          end else begin
            s_arp_response_ready <= 1'b1;
            if (sel_valid) begin
              s_arp_request_ready <= sel_grant;
              offer_idx <= sel_index;
            end
          end
        end
        REQ: begin
          if (m_arp_request_ready) begin
            m_arp_request_valid <= 1'b0;
            wdog <= '0;
            s_arp_response_ready <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (s_arp_response_valid || timeout_hit) begin
            m_arp_response_mac <= s_arp_response_valid ? s_arp_response_mac : '0;
            m_arp_response_error <= s_arp_response_valid ? s_arp_response_error : 1'b1;
            m_arp_response_valid <= owner_hot;
            s_arp_response_ready <= 1'b0;
            state <= RESP;
          end else if (wdog != '1) begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          if (m_arp_response_ready[grant_index]) begin
            m_arp_response_valid <= '0;
            busy <= 1'b0;
            s_arp_response_ready <= 1'b1;
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arp_req_arb.sv
// tb_arp_req_arb: directed stimulus with a transaction-level reference model checked every cycle
module tb_arp_req_arb;
  localparam int S = 2;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [S-1:0] s_req_valid, s_req_ready, c_resp_valid, c_resp_ready;
  logic [S*32-1:0] s_req_ip;
  logic c_resp_err;
  logic [47:0] c_resp_mac;
  logic m_req_valid, m_req_ready;
  logic [31:0] m_req_ip;
  logic a_resp_valid, a_resp_ready, a_resp_err;
  logic [47:0] a_resp_mac;
  logic busy;
  logic [0:0] gi;

  always #5 clk = ~clk;

  arp_req_arb #(.S_COUNT(S), .TIMEOUT(TO), .LSB_HIGH_PRIORITY(1)) dut (
    .clk(clk), .rst(rst),
    .s_arp_request_valid(s_req_valid), .s_arp_request_ready(s_req_ready), .s_arp_request_ip(s_req_ip),
    .m_arp_response_valid(c_resp_valid), .m_arp_response_ready(c_resp_ready),
    .m_arp_response_error(c_resp_err), .m_arp_response_mac(c_resp_mac),
    .m_arp_request_valid(m_req_valid), .m_arp_request_ready(m_req_ready), .m_arp_request_ip(m_req_ip),
    .s_arp_response_valid(a_resp_valid), .s_arp_response_ready(a_resp_ready),
    .s_arp_response_error(a_resp_err), .s_arp_response_mac(a_resp_mac),
    .busy(busy), .grant_index(gi)
  );

  int checks = 0, errors = 0;
  // reference model: transaction phase 0 idle, 1 lookup issued, 2 awaiting answer, 3 answer presented
  int ph = 0, owner = 0, ptr = 0, wait_cyc = 0, cd = 0, cyc = 0, mhs_cyc = 0;
  logic [31:0] arp_ip = '0;
  logic [S-1:0] e_offer = '0, e_cvalid = '0, hs_c = '0, rmask = '1;
  logic e_mvalid = 0, e_busy = 0, e_sready = 0, e_err = 0;
  logic [31:0] e_ip = '0;
  logic [47:0] e_mac = '0;
  int e_gi = 0;
  bit chk_en = 0, silent = 0, stray = 0;
  logic stray_taken = 0, prev_mvalid = 0;
  int lat = 3;
  logic [31:0] q0[$], q1[$];
  int grants[$], rise_cyc[$], hs_cyc[$], cresp_cyc[$];
  logic [31:0] rise_ip[$];
  logic [S-1:0] cresp_vec[$];
  logic [47:0] cresp_mac[$];
  logic cresp_err[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mac_of(logic [31:0] ip);
    return ip == 32'hC0A80164 ? 48'h5A5152535455 : {16'h0200, ip};
  endfunction

  function automatic int rr_win(logic [S-1:0] req, int p);
    for (int k = 0; k < S; k++)
      if (((req >> ((p + k) % S)) & 1) != 0) return (p + k) % S;
    return -1;
  endfunction

  initial forever begin
    int w;
    logic [S-1:0] hs;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      chk("s_req_ready", s_req_ready, e_offer);
      chk("m_req_valid", m_req_valid, e_mvalid);
      chk("m_req_ip", m_req_ip, e_ip);
      chk("grant_index", gi, e_gi);
      chk("busy", busy, e_busy);
      chk("c_resp_valid", c_resp_valid, e_cvalid);
      chk("c_resp_err", c_resp_err, e_err);
      chk("c_resp_mac", c_resp_mac, e_mac);
      chk("a_resp_ready", a_resp_ready, e_sready);
    end
    // environment: clients, ARP block
    if (hs_c[0]) void'(q0.pop_front());
    if (hs_c[1]) void'(q1.pop_front());
    s_req_valid = {q1.size() != 0, q0.size() != 0};
    s_req_ip = {q1.size() != 0 ? q1[0] : 32'h0, q0.size() != 0 ? q0[0] : 32'h0};
    c_resp_ready = rmask;
    m_req_ready = prev_mvalid;
    if (m_req_valid && !prev_mvalid) begin
      rise_cyc.push_back(cyc);
      rise_ip.push_back(m_req_ip);
    end
    prev_mvalid = m_req_valid;
    a_resp_valid = 0;
    a_resp_err = 0;
    a_resp_mac = '0;
    if (stray) begin
      stray = 0;
      stray_taken = a_resp_ready;
      a_resp_valid = 1;
      a_resp_mac = 48'h0000DEADBEEF;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        a_resp_valid = 1;
        a_resp_mac = mac_of(arp_ip);
        a_resp_err = arp_ip == 32'h0A0000FE;
      end
    end
    hs_c = s_req_valid & s_req_ready;
    if (hs_c != 0) hs_cyc.push_back(cyc);
    if (m_req_valid && m_req_ready) begin
      mhs_cyc = cyc;
      if (!silent) begin
        cd = lat;
        arp_ip = m_req_ip;
      end
    end
    if ((c_resp_valid & c_resp_ready) != 0) begin
      cresp_cyc.push_back(cyc);
      cresp_vec.push_back(c_resp_valid);
      cresp_mac.push_back(c_resp_mac);
      cresp_err.push_back(c_resp_err);
    end
    // model: expectations for the next cycle
    if (rst) begin
      ph = 0; ptr = 0; cd = 0; hs_c = '0;
      e_offer = '0; e_mvalid = 0; e_ip = '0; e_gi = 0; e_busy = 0;
      e_cvalid = '0; e_err = 0; e_mac = '0; e_sready = 0;
      chk_en = 1;
    end else begin
      case (ph)
        0: begin
          if (e_offer != 0) begin
            hs = s_req_valid & e_offer;
            e_offer = '0;
            e_sready = 1;
            if (hs != 0) begin
              for (int k = 0; k < S; k++) if (((hs >> k) & 1) != 0) owner = k;
              grants.push_back(owner);
              ptr = (owner + 1) % S;
              e_mvalid = 1;
              e_ip = 32'(s_req_ip >> (owner * 32));
              e_gi = owner;
              e_busy = 1;
              e_sready = 0;
              ph = 1;
            end
          end else begin
            e_sready = 1;
            w = rr_win(s_req_valid, ptr);
            e_offer = w < 0 ? '0 : S'(1) << w;
          end
        end
        1: if (m_req_ready) begin
          e_mvalid = 0;
          e_sready = 1;
          wait_cyc = 0;
          ph = 2;
        end
        2: begin
          wait_cyc++;
          if (a_resp_valid) begin
            e_cvalid = S'(1) << owner;
            e_mac = a_resp_mac;
            e_err = a_resp_err;
            e_sready = 0;
            ph = 3;
          end else if (wait_cyc == TO) begin
            e_cvalid = S'(1) << owner;
            e_mac = '0;
            e_err = 1;
            e_sready = 0;
            ph = 3;
          end
        end
        default: if (((c_resp_ready >> owner) & 1) != 0) begin
          e_cvalid = '0;
          e_busy = 0;
          e_sready = 1;
          ph = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    grants.delete(); rise_cyc.delete(); rise_ip.delete(); hs_cyc.delete();
    cresp_cyc.delete(); cresp_vec.delete(); cresp_mac.delete(); cresp_err.delete();
  endtask

  task automatic wait_done(int max);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(ph == 0 && q0.size() == 0 && q1.size() == 0 && cd == 0 && e_offer == 0) && n < max);
    if (n >= max) chk("wait_done_timeout", 1, 0);
  endtask

  initial begin
    s_req_valid = '0; s_req_ip = '0; c_resp_ready = '1; m_req_ready = 0;
    a_resp_valid = 0; a_resp_err = 0; a_resp_mac = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // single client lookup
    q0.push_back(32'hC0A80164);
    wait_done(200);
    chk("t1_grant_count", grants.size(), 1);
    chk("t1_grant", grants[0], 0);
    chk("t1_req_ip", rise_ip[0], 32'hC0A80164);
    chk("t1_req_latency", rise_cyc[0] - hs_cyc[0], 1);
    chk("t1_resp_vec", cresp_vec[0], 2'b01);
    chk("t1_resp_mac", cresp_mac[0], 48'h5A5152535455);
    chk("t1_resp_err", cresp_err[0], 0);
    chk("t1_busy_idle", busy, 0);
    // simultaneous requests from a fresh pointer; client 0 slow to accept
    rst = 1; tick(); rst = 0;
    clr();
    rmask = 2'b10;
    q0.push_back(32'h0A000001);
    q1.push_back(32'h0A000002);
    repeat (14) tick();
    rmask = 2'b11;
    wait_done(300);
    chk("t2_grant0", grants[0], 0);
    chk("t2_grant1", grants[1], 1);
    chk("t2_ip0", rise_ip[0], 32'h0A000001);
    chk("t2_ip1", rise_ip[1], 32'h0A000002);
    chk("t2_second_after_accept", rise_cyc[1] > cresp_cyc[0], 1);
    chk("t2_vec1", cresp_vec[1], 2'b10);
    // persistent re-requests alternate
    clr();
    q1.push_back(32'h0A000011); q1.push_back(32'h0A000012); q1.push_back(32'h0A000013);
    tick();
    q0.push_back(32'h0A000021); q0.push_back(32'h0A000022);
    wait_done(600);
    chk("t3_grant_count", grants.size(), 5);
    chk("t3_g0", grants[0], 1);
    chk("t3_g1", grants[1], 0);
    chk("t3_g2", grants[2], 1);
    chk("t3_g3", grants[3], 0);
    // watchdog expiry, then a late response in IDLE
    clr();
    silent = 1;
    q0.push_back(32'h0A000031);
    wait_done(400);
    chk("t4_timeout_cycles", cresp_cyc[0] - 1 - mhs_cyc, TO);
    chk("t4_err", cresp_err[0], 1);
    chk("t4_mac", cresp_mac[0], 48'h0);
    chk("t4_vec", cresp_vec[0], 2'b01);
    repeat (10) tick();
    stray = 1;
    repeat (6) tick();
    chk("t4_stray_consumed", stray_taken, 1);
    chk("t4_stray_no_client", cresp_cyc.size(), 1);
    silent = 0;
    // lookup error passthrough
    clr();
    q1.push_back(32'h0A0000FE);
    wait_done(200);
    chk("t5_vec", cresp_vec[0], 2'b10);
    chk("t5_err", cresp_err[0], 1);
    chk("t5_mac", cresp_mac[0], 48'h02000A0000FE);
    // reset while client 1 waits for an answer
    clr();
    silent = 1;
    q1.push_back(32'h0A000077);
    for (int n = 0; n < 50 && ph != 2; n++) tick();
    chk("t6_reached_wait", ph, 2);
    repeat (5) tick();
    rst = 1; tick(); rst = 0;
    chk("t6_busy", busy, 0);
    chk("t6_cvalid", c_resp_valid, 2'b00);
    chk("t6_mvalid", m_req_valid, 0);
    silent = 0;
    q0.push_back(32'h0A000088);
    wait_done(200);
    chk("t6_grant", grants[1], 0);
    chk("t6_resp_count", cresp_vec.size(), 1);
    chk("t6_vec", cresp_vec[0], 2'b01);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arp_req_arb.md
Name: arp_req_arb

Overview:
- Shares the single ARP request/response port of the ARP block between S_COUNT independent IP transmit requesters, for example several IP TX engines or a TX engine plus a static-route probe.
- Grants one requester at a time using round-robin arbitration.
- Forwards the granted requester's lookup IP to the ARP block and routes the ARP response back to that requester only.
- Holds the grant until the requester accepts the response. An optional watchdog converts a missing response into an error response.

Parameters:
- S_COUNT, 2, number of requesters (2..16).
- CL_S_COUNT, $clog2(S_COUNT), grant index width (derived).
- TIMEOUT, 0, cycles to wait for a downstream response before returning an error; 0 disables the watchdog.
- LSB_HIGH_PRIORITY, 1, priority order among simultaneous requests relative to the round-robin pointer; 1 means lower index wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- s_arp_request_valid  in  S_COUNT  per-requester request valid
- s_arp_request_ready  out  S_COUNT  per-requester request accept
- s_arp_request_ip  in  S_COUNT*32  per-requester lookup IP; requester i uses bits [32*i+:32]
- m_arp_response_valid  out  S_COUNT  per-requester response valid
- m_arp_response_ready  in  S_COUNT  per-requester response accept
- m_arp_response_error  out  1  response error flag, shared by all requesters
- m_arp_response_mac  out  48  response MAC, shared by all requesters
- m_arp_request_valid  out  1  request to the ARP block
- m_arp_request_ready  in  1  ARP block accepts the request
- m_arp_request_ip  out  32  lookup IP
- s_arp_response_valid  in  1  response from the ARP block
- s_arp_response_ready  out  1  accept response
- s_arp_response_error  in  1  ARP lookup failed
- s_arp_response_mac  in  48  resolved MAC
- busy  out  1  high in any state other than IDLE
- grant_index  out  CL_S_COUNT  current or last owner

Behaviour:
- Clock clk; reset rst, synchronous, active-high. All outputs are registered.
- Reset values:
  - all valid and ready outputs are 0;
  - m_arp_request_ip = 0, m_arp_response_mac = 0, m_arp_response_error = 0;
  - busy = 0, grant_index = 0;
  - round-robin pointer = 0, watchdog counter = 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If any s_arp_request_valid bit is set, select winner w. Search starts from the pointer position; with LSB_HIGH_PRIORITY=1 the search runs upward and wraps.
  - s_arp_request_ready[w] is high for exactly one cycle, and that cycle is the handshake.
  - Latch the IP into m_arp_request_ip and set grant_index = w. Next state is REQ with m_arp_request_valid = 1.
  - Pointer becomes w+1 modulo S_COUNT.
- REQ: hold m_arp_request_valid and m_arp_request_ip stable until m_arp_request_ready. On the handshake, deassert valid, clear the watchdog, and go to WAIT.
- WAIT:
  - s_arp_response_ready = 1.
  - On s_arp_response_valid, latch the MAC and error into the outputs, assert m_arp_response_valid[grant_index] only, and go to RESP.
  - If TIMEOUT != 0 and the watchdog reaches TIMEOUT-1 without a response: drive m_arp_response_error = 1 and m_arp_response_mac = 0, assert the owner's valid, and go to RESP.
- RESP: hold the outputs until m_arp_response_ready[grant_index]. Then clear valid and go to IDLE. Ready bits of non-owners are ignored.
- s_arp_response_ready is also 1 in IDLE. A stray or late response arriving there is consumed and dropped, with no client output. It is 0 in REQ and RESP.
- Minimum latencies:
  - client request handshake to m_arp_request_valid: 1 cycle;
  - s_arp_response handshake to m_arp_response_valid: 1 cycle;
  - back-to-back grants: the IDLE cycle after RESP completes.
- Boundary cases:
  - A requester that drops valid before its grant is simply skipped.
  - Simultaneous requests are served in round-robin order; no requester waits more than S_COUNT-1 grants.
  - A response arriving in the same cycle as the watchdog expiring: the real response wins.
  - Reset mid-transaction returns to IDLE immediately, with all valids deasserted and the pending transaction discarded.
- Watchdog counter width is $clog2(TIMEOUT+1) and it saturates; it counts only in WAIT.

Decomposition:
- Shared package: the state encodings (IDLE/REQ/WAIT/RESP) and the ARP field-width constants IP_W=32 and MAC_W=48.
- One natural sub-module: a round-robin priority encoder, arp_rr_select (inputs: request vector and pointer; outputs: valid, index, one-hot grant). Reusable by other arbiters in the stack.

Test Plan:
- Single client 0 requests IP 0xC0A80164; ARP block answers MAC 0x5A5152535455, error 0 → m_arp_request_ip=0xC0A80164 one cycle after the handshake; m_arp_response_valid=2'b01 with that MAC; busy returns to 0 after client ready.
- Clients 0 and 1 request together, with IPs 0x0A000001 and 0x0A000002 → serviced 0 then 1; the second m_arp_request_valid appears only after client 0 accepts its response; grant_index goes 0 then 1.
- Client 1 repeatedly re-requests while client 0 also holds a request (S_COUNT=2) → grants alternate 1,0,1,0; neither client starves.
- TIMEOUT=100 and the ARP block never responds → exactly 100 cycles after the request handshake, the owner receives error=1, mac=0. A response injected 10 cycles later, in IDLE, is consumed with no client valid.
- ARP block returns error=1 for 0x0A0000FE → the owner sees m_arp_response_error=1; the other client's valid stays 0.
- Assert rst during WAIT with client 1 owning the grant → next cycle all valid outputs are 0 and busy=0; a subsequent request from client 0 is granted normally.
